uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Oversampling asynchronous UART receiver: detects a start bit, samples mid-bit at 1/16 of the tick_baud_x16 rate, and shifts in 8 data bits LSB first, an optional parity bit and one stop bit.
- Presents each received byte with single-cycle valid, framing-error and parity-error flags.
- Used as the peripheral UART receive path and as a passive line monitor on a UART TX pin.

Parameters:
- None. Frame format is fixed: 1 start bit, 8 data bits, optional parity, 1 stop bit.

Ports:
- core_clk  input  1  clock
- rst_l  input  1  reset, asynchronous, active-low
- rx_enable  input  1  receiver enable; low forces idle
- tick_baud_x16  input  1  single-cycle pulse at 16x baud rate
- parity_enable  input  1  frame carries a parity bit
- parity_odd  input  1  1=odd parity, 0=even parity
- rx  input  1  serial line, idle high
- tick_baud  output  1  pulse on each bit-sample cycle
- rx_valid  output  1  one-cycle pulse, frame complete
- rx_data  output  8  received byte, valid while rx_valid=1
- idle  output  1  no frame in progress
- frame_err  output  1  stop bit sampled 0; qualifies rx_valid
- rx_parity_err  output  1  parity mismatch; qualifies rx_valid

Behaviour:
- All logic acts on core_clk. rx is sampled only in cycles where tick_baud_x16=1.
- Reset values: idle=1; tick_baud, rx_valid, frame_err and rx_parity_err are 0; rx_data=0.
- Internal state:
  - 4-bit oversample counter.
  - Bit counter.
  - 11-bit shift register.
  - Busy flag (idle = ~busy, registered).
- Start detection:
  - Trigger: not busy, rx_enable=1, tick_baud_x16=1, rx=0.
  - Action: set busy, load oversample counter with 8, load bit counter with 10 (parity_enable=0) or 11 (parity_enable=1).
- Sampling:
  - Each tick_baud_x16 while busy increments the counter.
  - When the counter wraps 15->0 it is a sample point: tick_baud=1 that cycle, rx is shifted into the MSB of the shift register (shift right), and the bit counter decrements.
  - The first sample point is mid start bit, 8 ticks after detection; later sample points follow every 16 ticks.
- False start: if rx=1 at the start-bit sample, clear busy; no rx_valid and no flags.
- Frame completion:
  - When the bit counter reaches 0 (stop bit sampled), clear busy.
  - In the next cycle: rx_valid=1 for exactly one cycle, and idle returns to 1 in that same cycle.
- Output decode:
  - rx_data = data bits taken from the shift register (the byte position depends on parity_enable).
  - frame_err = rx_valid & (stop bit == 0).
  - rx_parity_err = rx_valid & parity_enable & (XOR(data[7:0], parity_bit, parity_odd) == 1).
  - Even parity means data bits plus parity bit contain an even number of ones; odd parity means an odd number.
- rx_valid pulses for every completed frame, including errored frames. Consumers check frame_err, then rx_parity_err, then rx_valid.
- rx_enable=0 at any time, including mid-frame: synchronously clear busy and both counters, suppress rx_valid and both error flags, set idle=1.
- A new start can be detected on the first tick_baud_x16 after a frame completes. After a frame error with rx still low, the receiver retriggers immediately; no break detection.
- parity_enable and parity_odd must be held stable during a frame; a change mid-frame gives undefined data for that frame only.
- Without tick_baud_x16 pulses the state freezes.

Optional Feature:
- Macro: UART_RX_INPUT_SYNC_EN.
- Defined: rx passes through a two-flop synchronizer, reset to 1, before any use. This adds 2 core_clk cycles of latency to every sample and to rx_valid.
- Undefined: rx is used directly; the caller guarantees it is synchronous to core_clk.

Decomposition:
- Package uart_rx_pkg: frame-length constants (DATA_BITS=8, FRAME_BITS_NOPAR=10, FRAME_BITS_PAR=11, START_SAMPLE_OFFSET=8).
- Sub-module uart_rx_sync: two-flop synchronizer, instantiated only under UART_RX_INPUT_SYNC_EN.
- Everything else stays in uart_rx_deserializer.

Test Plan:
- tick_baud_x16 high every cycle, parity off, send 0x55 with a good stop bit (16 cycles per bit):
  - exactly one rx_valid pulse, rx_data=0x55, frame_err=0, rx_parity_err=0.
  - 10 tick_baud pulses.
  - idle=0 during the frame and 1 from the rx_valid cycle on.
- Parity on, even parity (parity_odd=0), send 0xA5:
  - parity bit 0 -> rx_data=0xA5, rx_parity_err=0.
  - parity bit 1 -> rx_parity_err=1 coincident with rx_valid.
- Parity on, odd parity (parity_odd=1), send 0x01 with parity bit 0 -> rx_parity_err=0.
- Send 0x3C with stop bit 0 -> rx_valid=1 with frame_err=1 and rx_data=0x3C.
- Glitch handling:
  - rx low for 4 ticks, then high -> no rx_valid, idle back to 1 after the start-bit sample.
  - A subsequent valid 0x7E frame is received correctly.
- Drop rx_enable during data bit 3 of a frame -> idle=1 next cycle, no rx_valid. Re-enable, send 0x41 -> rx_data=0x41.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared frame constants, state encoding and parity helper for the UART receiver.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS           = 8;
    localparam int unsigned FRAME_BITS_NOPAR    = 10;   // start + 8 data + stop
    localparam int unsigned FRAME_BITS_PAR      = 11;   // start + 8 data + parity + stop
    localparam int unsigned START_SAMPLE_OFFSET = 8;    // lands the first sample mid start bit
    localparam int unsigned OS_CNT_W            = 4;
    localparam int unsigned BIT_CNT_W           = 4;
    localparam int unsigned SHREG_W             = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } rx_state_e;

    // 1 when data plus parity bit disagree with the selected parity sense
    function automatic logic calc_parity_err(
        input logic [DATA_BITS-1:0] data,
        input logic                 par_bit,
        input logic                 par_odd
    );
        return (^data) ^ par_bit ^ par_odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level (1).
// Ports: core_clk, rst_l (async active-low), d (async in), q (synchronized out).
module uart_rx_sync (
    input  logic core_clk,
    input  logic rst_l,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge core_clk or negedge rst_l) begin
        if (!rst_l) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 16x oversampling UART receiver: start detect, mid-bit sampling, 8 data bits LSB
// first, optional parity, one stop bit. Each frame ends with a one-cycle rx_valid
// qualified by frame_err / rx_parity_err.
// Ports:
//   core_clk, rst_l                  clock, async active-low reset
//   rx_enable                        low forces idle (also mid-frame)
//   tick_baud_x16                    16x baud strobe; rx only sampled on these cycles
//   parity_enable, parity_odd        frame format
//   rx                               serial line, idle high
//   tick_baud                        pulse per bit sample
//   rx_valid, rx_data                received byte, one-cycle valid
//   idle                             no frame in progress
//   frame_err, rx_parity_err         error qualifiers for rx_valid
// Build option: UART_RX_INPUT_SYNC_EN inserts a two-flop synchronizer on rx
// (adds 2 core_clk of latency).
module uart_rx_deserializer
    import uart_rx_pkg::*;
(
    input  logic       core_clk,
    input  logic       rst_l,
    input  logic       rx_enable,
    input  logic       tick_baud_x16,
    input  logic       parity_enable,
    input  logic       parity_odd,
    input  logic       rx,
    output logic       tick_baud,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       idle,
    output logic       frame_err,
    output logic       rx_parity_err
);

    logic rx_s;

`ifdef UART_RX_INPUT_SYNC_EN
    uart_rx_sync u_rx_sync (
        .core_clk (core_clk),
        .rst_l    (rst_l),
        .d        (rx),
        .q        (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    rx_state_e              state;
    logic [OS_CNT_W-1:0]    os_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [SHREG_W-1:0]     shreg;

    logic [SHREG_W-1:0]     shreg_shift;
    logic [BIT_CNT_W-1:0]   frame_len;
    logic [DATA_BITS-1:0]   frame_data;
    logic                   frame_par;
    logic                   frame_stop;

    // Frame decode looks at the shift value including the sample being taken now,
    // so the result can be registered on the stop-bit sample edge.
    always_comb begin
        shreg_shift = {rx_s, shreg[SHREG_W-1:1]};
        frame_len   = parity_enable ? BIT_CNT_W'(FRAME_BITS_PAR)
                                    : BIT_CNT_W'(FRAME_BITS_NOPAR);
        frame_stop  = shreg_shift[10];
        frame_par   = shreg_shift[9];
        frame_data  = parity_enable ? shreg_shift[8:1] : shreg_shift[9:2];
    end

    // Receiver state machine with registered outputs
    always_ff @(posedge core_clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= ST_IDLE;
            os_cnt        <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            tick_baud     <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            idle          <= 1'b1;
            frame_err     <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            tick_baud     <= 1'b0;
            rx_valid      <= 1'b0;
            frame_err     <= 1'b0;
            rx_parity_err <= 1'b0;

            if (!rx_enable) begin
                state   <= ST_IDLE;
                os_cnt  <= '0;
                bit_cnt <= '0;
                idle    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tick_baud_x16 && !rx_s) begin
                            state   <= ST_BUSY;
                            os_cnt  <= OS_CNT_W'(START_SAMPLE_OFFSET);
                            bit_cnt <= frame_len;
                            idle    <= 1'b0;
                        end
                    end
                    ST_BUSY: begin
                        if (tick_baud_x16) begin
                            os_cnt <= os_cnt + OS_CNT_W'(1);
                            // 15->0 wrap is the sample point
                            if (os_cnt == '1) begin
                                tick_baud <= 1'b1;
                                shreg     <= shreg_shift;
                                bit_cnt   <= bit_cnt - BIT_CNT_W'(1);
                                if (bit_cnt == frame_len && rx_s) begin
                                    // start bit gone high by mid-bit: glitch, drop it
                                    state <= ST_IDLE;
                                    idle  <= 1'b1;
                                end else if (bit_cnt == BIT_CNT_W'(1)) begin
                                    state         <= ST_IDLE;
                                    idle          <= 1'b1;
                                    rx_valid      <= 1'b1;
                                    rx_data       <= frame_data;
                                    frame_err     <= ~frame_stop;
                                    rx_parity_err <= parity_enable &
                                                     calc_parity_err(frame_data, frame_par, parity_odd);
                                end
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        idle  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer (tick_baud_x16 held high,
// 16 core_clk per bit).
module tb_uart_rx_deserializer;

    logic       core_clk = 1'b0;
    logic       rst_l;
    logic       rx_enable;
    logic       tick_baud_x16;
    logic       parity_enable;
    logic       parity_odd;
    logic       rx;
    logic       tick_baud;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       idle;
    logic       frame_err;
    logic       rx_parity_err;

    int checks = 0;
    int errors = 0;

    // monitor state (written only by the monitor process)
    int         valid_cnt   = 0;
    int         tick_cnt    = 0;
    int         busy_cycles = 0;
    logic [7:0] cap_data    = 8'h00;
    logic       cap_fe      = 1'b0;
    logic       cap_pe      = 1'b0;
    logic       cap_idle    = 1'b0;

    always #5 core_clk = ~core_clk;

    uart_rx_deserializer dut (
        .core_clk      (core_clk),
        .rst_l         (rst_l),
        .rx_enable     (rx_enable),
        .tick_baud_x16 (tick_baud_x16),
        .parity_enable (parity_enable),
        .parity_odd    (parity_odd),
        .rx            (rx),
        .tick_baud     (tick_baud),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .idle          (idle),
        .frame_err     (frame_err),
        .rx_parity_err (rx_parity_err)
    );

    always @(negedge core_clk) begin
        if (rst_l) begin
            if (rx_valid) begin
                valid_cnt <= valid_cnt + 1;
                cap_data  <= rx_data;
                cap_fe    <= frame_err;
                cap_pe    <= rx_parity_err;
                cap_idle  <= idle;
            end
            if (tick_baud)
                tick_cnt <= tick_cnt + 1;
            if (!idle)
                busy_cycles <= busy_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(posedge core_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
        if (par_en)
            drive_bit(par_bit);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    int v0;
    int t0;
    int b0;

    initial begin
        rst_l         = 1'b0;
        rx_enable     = 1'b1;
        tick_baud_x16 = 1'b1;
        parity_enable = 1'b0;
        parity_odd    = 1'b0;
        rx            = 1'b1;

        // reset state
        repeat (3) @(negedge core_clk);
        check("rst_idle",      32'(idle),          32'd1);
        check("rst_tick_baud", 32'(tick_baud),     32'd0);
        check("rst_rx_valid",  32'(rx_valid),      32'd0);
        check("rst_frame_err", 32'(frame_err),     32'd0);
        check("rst_par_err",   32'(rx_parity_err), 32'd0);
        check("rst_rx_data",   32'(rx_data),       32'h00);
        @(posedge core_clk);
        #1 rst_l = 1'b1;
        gap(20);

        // 0x55, no parity, good stop
        v0 = valid_cnt; t0 = tick_cnt; b0 = busy_cycles;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        gap(40);
        check("f55_valid_cnt", 32'(valid_cnt - v0),   32'd1);
        check("f55_data",      32'(cap_data),         32'h55);
        check("f55_frame_err", 32'(cap_fe),           32'd0);
        check("f55_par_err",   32'(cap_pe),           32'd0);
        check("f55_ticks",     32'(tick_cnt - t0),    32'd10);
        check("f55_busy_cyc",  32'(busy_cycles - b0), 32'd152);
        check("f55_idle_at_v", 32'(cap_idle),         32'd1);
        check("f55_idle_end",  32'(idle),             32'd1);

        // even parity, 0xA5, correct parity bit
        parity_enable = 1'b1;
        parity_odd    = 1'b0;
        v0 = valid_cnt; t0 = tick_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        gap(40);
        check("a5e_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("a5e_data",      32'(cap_data),       32'hA5);
        check("a5e_par_err",   32'(cap_pe),         32'd0);
        check("a5e_ticks",     32'(tick_cnt - t0),  32'd11);

        // even parity, 0xA5, wrong parity bit
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        gap(40);
        check("a5b_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("a5b_data",      32'(cap_data),       32'hA5);
        check("a5b_par_err",   32'(cap_pe),         32'd1);
        check("a5b_frame_err", 32'(cap_fe),         32'd0);

        // odd parity, 0x01, parity bit 0
        parity_odd = 1'b1;
        v0 = valid_cnt;
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        gap(40);
        check("o01_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("o01_data",      32'(cap_data),       32'h01);
        check("o01_par_err",   32'(cap_pe),         32'd0);

        // 0x3C with a bad stop bit, parity off
        parity_enable = 1'b0;
        parity_odd    = 1'b0;
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        gap(60);
        check("f3c_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("f3c_data",      32'(cap_data),       32'h3C);
        check("f3c_frame_err", 32'(cap_fe),         32'd1);
        check("f3c_par_err",   32'(cap_pe),         32'd0);

        // 4-tick glitch on rx: only the start sample happens
        v0 = valid_cnt; t0 = tick_cnt;
        rx = 1'b0;
        gap(4);
        rx = 1'b1;
        gap(30);
        check("gl_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        check("gl_ticks",     32'(tick_cnt - t0),  32'd1);
        check("gl_idle",      32'(idle),           32'd1);

        // clean frame after the glitch
        v0 = valid_cnt;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        gap(40);
        check("f7e_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("f7e_data",      32'(cap_data),       32'h7E);
        check("f7e_frame_err", 32'(cap_fe),         32'd0);

        // drop rx_enable mid data bit 3
        v0 = valid_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b1;
        gap(8);
        check("dis_busy_before", 32'(idle), 32'd0);
        rx_enable = 1'b0;
        @(posedge core_clk);
        @(negedge core_clk);
        check("dis_idle_next", 32'(idle), 32'd1);
        gap(120);
        check("dis_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        check("dis_idle_hold", 32'(idle),            32'd1);

        // re-enable and receive 0x41
        rx_enable = 1'b1;
        gap(20);
        v0 = valid_cnt;
        send_frame(8'h41, 1'b0, 1'b0, 1'b1);
        gap(40);
        check("f41_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("f41_data",      32'(cap_data),       32'h41);
        check("f41_frame_err", 32'(cap_fe),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
